ex_wb_stage: RTL
================

# ex_wb_stage

Execute-to-writeback pipeline stage sitting directly downstream of the 8-bit ALU. It registers the ALU result and flag array and drives the register-file write port. It owns the architectural flag register (parity, positive, carry, zero) and returns the committed carry to the ALU `Cin`. It also provides result forwarding to the operand muxes and a retired-instruction counter.

## Interface
- `RET_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ex_valid`  in  1  execute slot holds a real instruction this cycle.
- `ex_rd`  in  3  destination register index (R0..R7).
- `ex_wr_en`  in  1  instruction writes `ex_rd`.
- `ex_flag_we`  in  4  per-bit flag update enable, same bit order as `alu_flags`.
- `alu_out`  in  8  ALU result.
- `alu_flags`  in  4  `{OddParity, Positive, Cout, Zero}` from the ALU.
- `stall`  in  1  hazard unit freeze: hold the WB register and the flags.
- `flush`  in  1  discard the current execute-slot instruction.
- `rf_we`  out  1  register-file write strobe.
- `rf_waddr`  out  3  register-file write address.
- `rf_wdata`  out  8  register-file write data.
- `flags_q`  out  4  architectural flag register.
- `cin_out`  out  1  carry to ALU `Cin`.
- `fwd_valid`  out  1  WB register holds a pending register write.
- `fwd_rd`  out  3  forwarded destination index.
- `fwd_data`  out  8  forwarded data.
- `retired`  out  RET_W  count of committed instructions.

## Operation
- Capture condition: `cap = ex_valid & ~stall & ~flush`.
- On `cap`, the WB register loads `{ex_wr_en, ex_rd, alu_out}` and sets `wb_valid`=1.
- When not `stall` and not `cap` (bubble or flush), `wb_valid` goes to 0.
- `stall`=1 with `flush`=0: the WB register, flags and counter all hold.
- `flush` has priority over `stall`. A flushed instruction never updates flags, the counter or the register file.
- Flag update on `cap`: for each bit i, `flags_q[i] <= ex_flag_we[i] ? alu_flags[i] : flags_q[i]`.
- `rf_we = wb_valid & wb_wr_en & ~stall`. `rf_waddr` and `rf_wdata` come from the WB register.
- A held instruction writes only in its first non-stalled cycle. Because it is held, the write is issued once, when the stall releases.
- `retired` increments by 1 on each `cap`. It wraps from all-ones to 0 with no flag.
- Reset values (after the first edge with `reset`=1):
  - `wb_valid`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `flags_q`=4'b0000, `cin_out`=0.
  - `fwd_valid`=0, `retired`=0.
- Reset overrides `stall` and `flush`. A reset mid-stall drops the held instruction.
- `alu_flags` and `alu_out` are sampled only on `cap`. Undefined ALU output in non-capture cycles must not propagate.

## Timing
- Latency: execute cycle N with `cap` gives `rf_we` in cycle N+1, and the register file commits at the end of N+1.
- Flags change at the end of cycle N. The next ALU op (cycle N+1) sees the new `cin_out`, so back-to-back ADC/SBC chains work with no bubble.
- `fwd_*` are valid in cycle N+1, combinationally from the WB register.
- No combinational path from `ex_*` or `alu_*` to any output.

## Configuration
- `EX_WB_FWD_EN` defined:
  - `fwd_valid = wb_valid & wb_wr_en`.
  - `fwd_rd` and `fwd_data` mirror the WB register.
- `EX_WB_FWD_EN` undefined:
  - `fwd_valid` is tied 0; `fwd_rd` and `fwd_data` are tied 0.
  - The hazard unit must stall one extra cycle on RAW.
- Ports exist in both builds.

## Structure
- Shared package `rnbip_pkg`:
  - Flag bit index constants: `FLG_Z`=0, `FLG_C`=1, `FLG_P`=2 (Positive), `FLG_OP`=3 (OddParity).
  - Register-index width constant (3).
  - Data width constant (8).
- One sub-module `flag_reg` for the masked 4-bit flag register with hold. Everything else is flat.

## Test plan
- Reset: assert `reset` for 2 cycles with `ex_valid`=1 → all outputs 0 and `retired`=0.
- ADD: `alu_out`=8'h3C, `ex_rd`=5, `ex_wr_en`=1, `ex_flag_we`=4'hF, `alu_flags`=4'b0100 → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=8'h3C; `flags_q`=4'b0100; `retired`=1.
- Masked flags: `flags_q`=4'b0011, `ex_flag_we`=4'b0010, `alu_flags`=4'b1100 → `flags_q`=4'b0001 and `cin_out`=0.
- Stall: instruction captured, then `stall`=1 for 3 cycles → `rf_we`=0 throughout and data held. When `stall` drops, a single `rf_we` pulse occurs with the same data and `retired` unchanged.
- Flush with stall: `flush`=1, `stall`=1, `ex_valid`=1 → `wb_valid`=0 and flags and `retired` unchanged.
- Wrap: preload `retired`=16'hFFFF via 65535 captures (or a forced value) plus one more `cap` → `retired`=0; with `EX_WB_FWD_EN` the `fwd_data` matches `rf_wdata`, and without it `fwd_valid` stays 0.

Source files
------------

// File: rtl/rnbip_pkg.sv
// Shared definitions for the RNBIP datapath: widths, flag bit positions,
// the writeback register payload and the masked flag-merge helper.
package rnbip_pkg;

    // Datapath and register-file geometry
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned FLAG_W    = 4;

    // Flag bit positions inside the {OddParity, Positive, Cout, Zero} array
    localparam int unsigned FLG_Z  = 0;
    localparam int unsigned FLG_C  = 1;
    localparam int unsigned FLG_P  = 2;
    localparam int unsigned FLG_OP = 3;

    // Payload held in the writeback register alongside its valid bit
    typedef struct packed {
        logic                 wr_en;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

    // Per-bit select: enabled bits take the new value, the rest keep the old one
    function automatic logic [FLAG_W-1:0] flag_merge(
        input logic [FLAG_W-1:0] old_flags,
        input logic [FLAG_W-1:0] new_flags,
        input logic [FLAG_W-1:0] we
    );
        return (old_flags & ~we) | (new_flags & we);
    endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural flag register with per-bit write enables and hold.
// Only updates when upd_i is high; synchronous active-high reset clears it.
module flag_reg
    import rnbip_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_i,
    input  logic [FLAG_W-1:0] we_i,
    input  logic [FLAG_W-1:0] flags_i,
    output logic [FLAG_W-1:0] flags_o
);

    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] flags_q;

    // Next state: merge enabled bits only on an update, otherwise hold
    always_comb begin
        flags_d = flags_q;
        if (upd_i) begin
            flags_d = flag_merge(flags_q, flags_i, we_i);
        end
    end

    // Flag state register
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: registers the ALU result, drives the register
// file write port, owns the flag register and counts retired instructions.
// Optional feature macro: EX_WB_FWD_EN enables result forwarding from the WB
// register; when undefined the fwd_* ports are tied to zero.
module ex_wb_stage
    import rnbip_pkg::*;
#(
    parameter int unsigned RET_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_wr_en,
    input  logic [FLAG_W-1:0]    ex_flag_we,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic [FLAG_W-1:0]    alu_flags,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [FLAG_W-1:0]    flags_q,
    output logic                 cin_out,
    output logic                 fwd_valid,
    output logic [REG_IDX_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]    fwd_data,
    output logic [RET_W-1:0]     retired
);

    logic            cap;
    logic            wb_valid_d;
    logic            wb_valid_q;
    wb_entry_t       wb_d;
    wb_entry_t       wb_q;
    logic [RET_W-1:0] retired_d;
    logic [RET_W-1:0] retired_q;

    // A flushed or stalled slot never reaches writeback
    assign cap = ex_valid & ~stall & ~flush;

    // WB register next state: load on capture, drop on bubble/flush, hold on stall.
    // Payload is left untouched when not capturing so ALU X never enters it.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_d       = wb_q;
        if (cap) begin
            wb_valid_d = 1'b1;
            wb_d.wr_en = ex_wr_en;
            wb_d.rd    = ex_rd;
            wb_d.data  = alu_out;
        end else if (flush || !stall) begin
            wb_valid_d = 1'b0;
        end
    end

    // WB register state
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
        end
    end

    // Retired counter next state: wraps silently
    always_comb begin
        retired_d = retired_q;
        if (cap) begin
            retired_d = retired_q + RET_W'(1);
        end
    end

    // Retired counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    flag_reg u_flag_reg (
        .clk     (clk),
        .reset   (reset),
        .upd_i   (cap),
        .we_i    (ex_flag_we),
        .flags_i (alu_flags),
        .flags_o (flags_q)
    );

    // Committed carry feeds the next ALU op directly, so ADC chains need no bubble
    assign cin_out = flags_q[FLG_C];

    // A held instruction only writes once the stall releases
    assign rf_we    = wb_valid_q & wb_q.wr_en & ~stall;
    assign rf_waddr = wb_q.rd;
    assign rf_wdata = wb_q.data;
    assign retired  = retired_q;

`ifdef EX_WB_FWD_EN
    assign fwd_valid = wb_valid_q & wb_q.wr_en;
    assign fwd_rd    = wb_q.rd;
    assign fwd_data  = wb_q.data;
`else
    // Without forwarding the hazard unit must stall an extra cycle on RAW
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule
